// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of (pc, instr) between fetch and decode.
// Optional FETCHQ_BYPASS_EN: empty-queue words pass combinationally to decode.
module fetch_queue #(
    parameter int bits  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [bits-1:0]         in_pc,
    input  logic [bits-1:0]         in_instr,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [bits-1:0]         out_pc,
    output logic [bits-1:0]         out_instr,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [bits-1:0] pc_q    [DEPTH];
    logic [bits-1:0] pc_d    [DEPTH];
    logic [bits-1:0] instr_q [DEPTH];
    logic [bits-1:0] instr_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    assign count = count_q;

    // Status flags, decode-side view and handshake qualification
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        in_ready = !full;
        pop      = !empty && out_ready;
`ifdef FETCHQ_BYPASS_EN
        if (empty && in_valid && !flush) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
            push      = !out_ready;
        end else begin
            out_valid = !empty;
            out_pc    = pc_q[rd_ptr_q];
            out_instr = instr_q[rd_ptr_q];
            push      = in_valid && in_ready;
        end
`else
        out_valid = !empty;
        out_pc    = pc_q[rd_ptr_q];
        out_instr = instr_q[rd_ptr_q];
        push      = in_valid && in_ready;
`endif
    end

    // Next-state: flush wins over push/pop; storage is left as-is on flush
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d[wr_ptr_q]    = in_pc;
                instr_d[wr_ptr_q] = in_instr;
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; storage also clears so outputs read 0 after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
